// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    FLUSH,
    RUN,
    ERROR
  } state_e;

  localparam int HDR_BYTES        = 2;
  localparam int INST_WIDTH_DFLT  = 32;
  localparam int BYTES_PER_WORD   = INST_WIDTH_DFLT / 8;

  function automatic int bytes_per_word(input int inst_width);
    return inst_width / 8;
  endfunction

endpackage

// File: rtl/inst_mem_loader_byte_word_packer.sv
// Shifts stream bytes MSB-first into an instruction word and flags the last byte.
module byte_word_packer
  import mips_loader_pkg::*;
#(
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            byte_i,
  input  logic                  take_i,
  output logic                  word_valid_o,
  output logic [INST_WIDTH-1:0] word_o
);

  localparam int BPW = bytes_per_word(INST_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]         cnt_q;
  logic [INST_WIDTH-1:0] word_q;
  logic [INST_WIDTH-1:0] word_d;
  logic                  last;

  assign last   = (cnt_q == CW'(BPW - 1));
  assign word_d = (word_q << 8) | INST_WIDTH'(byte_i);

  // The completed word is offered on the same cycle the last byte is taken,
  // so the owner can register it without a bubble.
  assign word_valid_o = take_i && last;
  assign word_o       = word_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (take_i) begin
      word_q <= word_d;
      cnt_q  <= last ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction-memory
// writes and holds the processor stalled until the final word has committed.
module inst_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  state_e                state_q;
  logic [15:0]           hdr_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic                  in_ready_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [INST_WIDTH-1:0] mem_wdata_q;
  logic                  cpu_run_q;
  logic                  load_error_q;

  logic                  xfer;
  logic                  take;
  logic                  word_valid;
  logic [INST_WIDTH-1:0] word;
  logic [15:0]           hdr_n;
  logic [16:0]           words_inc;

  assign xfer      = in_valid && in_ready_q;
  assign take      = xfer && (state_q == DATA);
  assign hdr_n     = {hdr_q[15:8], in_data};
  assign words_inc = 17'(words_q) + 17'd1;

  byte_word_packer #(
    .INST_WIDTH (INST_WIDTH)
  ) u_packer (
    .clk_i        (clock),
    .rst_i        (reset),
    .byte_i       (in_data),
    .take_i       (take),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= HDR_HI;
      hdr_q        <= '0;
      words_q      <= '0;
      in_ready_q   <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_run_q    <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        HDR_HI: if (xfer) begin
          hdr_q[15:8] <= in_data;
          state_q     <= HDR_LO;
        end
        HDR_LO: if (xfer) begin
          hdr_q[7:0] <= in_data;
          if ({1'b0, hdr_n} > DEPTH) begin
            state_q      <= ERROR;
            in_ready_q   <= 1'b0;
            load_error_q <= 1'b1;
          end else if (hdr_n == 16'd0) begin
            state_q    <= FLUSH;
            in_ready_q <= 1'b0;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (word_valid) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= words_q[ADDR_WIDTH-1:0];
          mem_wdata_q <= word;
          words_q     <= words_q + 1'b1;
          if (words_inc == {1'b0, hdr_q}) begin
            state_q    <= FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        // One dead cycle lets the final mem_we commit before the first fetch.
        FLUSH: begin
          state_q   <= RUN;
          cpu_run_q <= 1'b1;
        end
        RUN:     state_q <= RUN;
        ERROR:   state_q <= ERROR;
        default: state_q <= ERROR;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized self-checking bench for inst_mem_loader against a word-level model.
module tb_inst_mem_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        load_error;
  logic [10:0] words_loaded;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wr_q[$];
  int  dbl;
  int  vecs;
  int  errs;
  logic we_prev;

  inst_mem_loader #(.ADDR_WIDTH(10), .INST_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write monitor: every strobe is logged; a strobe longer than one cycle is flagged.
  initial we_prev = 1'b0;
  always @(negedge clock) begin
    if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
    if (mem_we === 1'b1 && we_prev === 1'b1) dbl = dbl + 1;
    we_prev = mem_we;
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wr_q.delete();
    dbl = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input string nm);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL %s ready: in_ready=%b want 1", nm, in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) @(posedge clock);
  endtask

  // Model: header is the word count, words go out MSB first, write i lands at address i.
  task automatic load_and_check(input logic [31:0] words[$], input int gmin,
                                input int gmax, input string nm);
    logic [7:0] s[$];
    int n;
    n = words.size();
    s.push_back(n[15:8]);
    s.push_back(n[7:0]);
    foreach (words[i])
      for (int k = 3; k >= 0; k--) s.push_back(words[i][8*k +: 8]);
    wr_q.delete();
    dbl = 0;
    for (int i = 0; i < s.size(); i++)
      send(s[i], (i == s.size() - 1) ? 0 : int'($urandom_range(gmax, gmin)), nm);
    @(negedge clock);
    vecs++;
    if (mem_we !== (n > 0) || cpu_run !== 1'b0) begin
      errs++;
      $display("FAIL %s flush: mem_we=%b cpu_run=%b want %b 0", nm, mem_we, cpu_run, n > 0);
    end
    @(negedge clock);
    vecs++;
    if (cpu_run !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || load_error !== 1'b0) begin
      errs++;
      $display("FAIL %s run: cpu_run=%b in_ready=%b mem_we=%b err=%b want 1 0 0 0",
               nm, cpu_run, in_ready, mem_we, load_error);
    end
    vecs++;
    if (words_loaded !== 11'(n) || wr_q.size() != n || dbl != 0) begin
      errs++;
      $display("FAIL %s count: words_loaded=%0d writes=%0d long=%0d want %0d %0d 0",
               nm, words_loaded, wr_q.size(), dbl, n, n);
    end
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      vecs++;
      if (wr_q[i].a !== 10'(i) || wr_q[i].d !== words[i]) begin
        errs++;
        $display("FAIL %s write%0d: addr=%0d data=%h want %0d %h",
                 nm, i, wr_q[i].a, wr_q[i].d, i, words[i]);
      end
    end
  endtask

  task automatic check_reset_vals(input string nm);
    vecs++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0 ||
        cpu_run !== 1'b0 || load_error !== 1'b0 || words_loaded !== 11'd0) begin
      errs++;
      $display("FAIL %s: rdy=%b we=%b addr=%h wd=%h run=%b err=%b wl=%0d want 1 0 0 0 0 0 0",
               nm, in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_error, words_loaded);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    #13;
    check_reset_vals("reset");
    do_reset();
    check_reset_vals("reset_release");
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    w = '{32'h20010005, 32'h8C020000};
    do_reset();
    load_and_check(w, 0, 0, "basic");
  endtask

  task automatic test_toggle();
    logic [31:0] w[$];
    w = '{32'h20010005, 32'h8C020000};
    do_reset();
    load_and_check(w, 1, 1, "toggle");
  endtask

  task automatic test_zero();
    logic [31:0] w[$];
    do_reset();
    load_and_check(w, 0, 0, "zero");
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    for (int t = 0; t < 5; t++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(24, 1)); i++) w.push_back($urandom);
      do_reset();
      load_and_check(w, 0, 3, "random");
    end
  endtask

  task automatic test_error();
    do_reset();
    send(8'h04, 0, "error_hdr");
    send(8'h01, 0, "error_hdr");
    @(negedge clock);
    vecs++;
    if (load_error !== 1'b1 || in_ready !== 1'b0 || cpu_run !== 1'b0) begin
      errs++;
      $display("FAIL error_enter: err=%b rdy=%b run=%b want 1 0 0", load_error, in_ready, cpu_run);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'($urandom);
      @(negedge clock);
    end
    in_valid = 1'b0;
    @(negedge clock);
    vecs++;
    if (load_error !== 1'b1 || in_ready !== 1'b0 || cpu_run !== 1'b0 ||
        words_loaded !== 11'd0 || wr_q.size() != 0) begin
      errs++;
      $display("FAIL error_hold: err=%b rdy=%b run=%b wl=%0d writes=%0d want 1 0 0 0 0",
               load_error, in_ready, cpu_run, words_loaded, wr_q.size());
    end
  endtask

  task automatic test_full();
    logic [31:0] w[$];
    for (int i = 0; i < 1024; i++)
      w.push_back({8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)});
    do_reset();
    load_and_check(w, 0, 0, "full");
    vecs++;
    if (wr_q.size() != 1024 || wr_q[wr_q.size()-1] !== {10'd1023, 32'hFCFDFEFF} ||
        words_loaded !== 11'd1024) begin
      errs++;
      $display("FAIL full_last: writes=%0d wl=%0d want 1024 1024 last 3ff/fcfdfeff",
               wr_q.size(), words_loaded);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    do_reset();
    load_and_check(w, 0, 0, "pre_run");
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("reset_in_run");
    @(negedge clock);
    reset = 1'b0;
    wr_q.delete();
    send(8'h00, 0, "partial");
    send(8'h02, 0, "partial");
    for (int i = 0; i < 7; i++) send(8'($urandom), 0, "partial");
    #2 reset = 1'b1;
    #1;
    check_reset_vals("reset_mid_word");
    vecs++;
    if (wr_q.size() != 1) begin
      errs++;
      $display("FAIL partial_writes: writes=%0d want 1", wr_q.size());
    end
    @(negedge clock);
    reset = 1'b0;
    w.push_back(32'h00000000);
    load_and_check(w, 0, 0, "reload");
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    dbl  = 0;
    test_reset();
    test_basic();
    test_toggle();
    test_zero();
    test_random();
    test_error();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
